ahb_lite_arbiter_2m: RTL

AHB_LITE_ARBITER_2M -- requirements
Module: ahb_lite_arbiter_2m

---
 rtl/ahb_lite_arbiter_2m.sv | 114 +++++++++++
 1 files changed

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter: the address-phase owner is a two-state FSM, and a
// data-phase owner register steers write data and the error response.
//
//   state | meaning
//   OWN0  | master 0 drives the address phase
//   OWN1  | master 1 drives the address phase
module ahb_lite_arbiter_2m #(
    parameter int DEFAULT_MASTER = 0,
    parameter int LOCK_ENABLE    = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [3:0]  M_HTRANS,
    input  logic [63:0] M_HADDR,
    input  logic [1:0]  M_HWRITE,
    input  logic [1:0]  M_HMASTLOCK,
    input  logic [5:0]  M_HSIZE,
    input  logic [5:0]  M_HBURST,
    input  logic [7:0]  M_HPROT,
    input  logic [63:0] M_HWDATA,
    output logic [1:0]  M_HREADY,
    output logic [1:0]  M_HRESP,
    output logic [31:0] M_HRDATA,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [1:0]  HTRANS,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic        GRANT
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic {OWN0, OWN1} state_t;

    state_t     state;
    logic       data_owner;
    logic [1:0] trans0;
    logic [1:0] trans1;
    logic [1:0] own_trans;
    logic [1:0] other_trans;
    logic       own_lock;
    logic       lock_hold;
    logic       handoff;

    assign trans0 = M_HTRANS[1:0];
    assign trans1 = M_HTRANS[3:2];

    always_comb begin
        own_trans   = (state == OWN1) ? trans1 : trans0;
        other_trans = (state == OWN1) ? trans0 : trans1;
        own_lock    = (state == OWN1) ? M_HMASTLOCK[1] : M_HMASTLOCK[0];
        lock_hold   = own_lock && (LOCK_ENABLE != 0);
        handoff     = HREADY && (own_trans == TRANS_IDLE) && !lock_hold
                      && (other_trans == TRANS_NONSEQ);
    end

    // A stalled slave (HREADY=0) freezes both the owner FSM and the data-phase owner.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= (DEFAULT_MASTER != 0) ? OWN1 : OWN0;
            data_owner <= (DEFAULT_MASTER != 0);
        end else if (HREADY) begin
            data_owner <= (state == OWN1);
            if (handoff) begin
                state <= (state == OWN1) ? OWN0 : OWN1;
            end
        end
    end

    assign GRANT = (state == OWN1);

    always_comb begin
        if (state == OWN1) begin
            HADDR     = M_HADDR[63:32];
            HWRITE    = M_HWRITE[1];
            HSIZE     = M_HSIZE[5:3];
            HBURST    = M_HBURST[5:3];
            HPROT     = M_HPROT[7:4];
            HTRANS    = trans1;
            HMASTLOCK = M_HMASTLOCK[1];
        end else begin
            HADDR     = M_HADDR[31:0];
            HWRITE    = M_HWRITE[0];
            HSIZE     = M_HSIZE[2:0];
            HBURST    = M_HBURST[2:0];
            HPROT     = M_HPROT[3:0];
            HTRANS    = trans0;
            HMASTLOCK = M_HMASTLOCK[0];
        end
    end

    assign HWDATA   = data_owner ? M_HWDATA[63:32] : M_HWDATA[31:0];
    assign M_HRDATA = HRDATA;

    // A waiting non-owner (SEQ treated like NONSEQ) is stalled; idle/busy get a zero-wait OKAY.
    always_comb begin
        M_HREADY[0] = (state == OWN0) ? HREADY
                    : !((trans0 == TRANS_NONSEQ) || (trans0 == TRANS_SEQ));
        M_HREADY[1] = (state == OWN1) ? HREADY
                    : !((trans1 == TRANS_NONSEQ) || (trans1 == TRANS_SEQ));
        M_HRESP[0]  = (data_owner == 1'b0) ? HRESP : 1'b0;
        M_HRESP[1]  = (data_owner == 1'b1) ? HRESP : 1'b0;
    end

endmodule
